flash_light_bank: RTL and testbench
===================================

Name: flash_light_bank

Overview:
Multi-channel successor to the single-LED flasher. Runs CHANNELS independent flash engines from one 40 MHz clock, using an internal shared tick prescaler instead of a second slow clock domain. Each channel is started by a one-cycle trigger pulse, flashes for a programmable number of tick periods, and can be cancelled or retriggered. Sits between parking-event logic (slot full / gate alarms) and the board LEDs.

Parameters:
CHANNELS, 4, number of independent LED channels (>=1)
TICK_DIV, 20000000, clk_40MHz cycles per flash tick (>=2); 20000000 gives 0.5 s per tick
FLASH_COUNT, 6, tick periods per flash sequence (1 .. 2^CNT_W-1)
CNT_W, 4, width of the per-channel sequence counter

Ports:
clk_40MHz  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
trigger  input  CHANNELS  per-channel start/retrigger pulse, one clk_40MHz cycle wide
cancel  input  CHANNELS  per-channel abort, level or pulse
led  output  CHANNELS  LED drive, active-high
busy  output  CHANNELS  high while channel is ARMED or FLASH
done  output  CHANNELS  one-cycle pulse when a sequence completes normally
tick  output  1  one-cycle pulse at each prescaler wrap (debug/visibility)

Behaviour:
- Reset (reset_n low, async): prescaler=0, all channels IDLE, cnt=0, pending=0; led=0, busy=0, done=0, tick=0.
- Prescaler: free-running 0..TICK_DIV-1, shared by all channels, never restarted by triggers. tick is registered high for exactly the cycle after the count reaches TICK_DIV-1 (period TICK_DIV cycles). Width = clog2(TICK_DIV).
- Per-channel FSM states: IDLE, ARMED, FLASH.
- pending flag: set on the clk edge where trigger[i]=1. Tick logic uses the registered pending value, so a trigger coincident with tick is served on the following tick.
- IDLE: pending=1 -> ARMED (busy=1 next cycle).
- ARMED, on tick: -> FLASH; cnt<=FLASH_COUNT; led<=1; pending<=0.
- FLASH, on tick with pending=1: restart; cnt<=FLASH_COUNT; led<=1; pending<=0.
- FLASH, on tick with cnt>1: cnt<=cnt-1; led<=~led.
- FLASH, on tick with cnt==1: cnt<=0; led<=0; -> IDLE; done pulses for 1 cycle. busy falls on the same edge.
- FLASH_COUNT=6 sequence, ticks T0..T6: led 1,0,1,0,1,0 then 0 plus done at T6. LED is on for 3 tick periods; busy lasts from trigger to T6.
- FLASH_COUNT=1: led=1 for one tick period, then done.
- cancel[i]=1 has highest priority. Next edge: IDLE, led=0, cnt=0, pending=0, no done. Trigger in the same cycle as cancel is discarded.
- Channels are fully independent. Simultaneous triggers on several channels are all honoured, and those channels flash in phase.
- Trigger while ARMED: no effect (already pending).
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
FLASH_TRIG_SYNC_EN
- Defined: trigger and cancel each pass through a 2-flop synchroniser plus rising-edge detector before the FSM. Inputs may then be asynchronous levels. Adds 3 cycles of latency to pending/cancel. A held-high trigger counts as one event.
- Undefined: inputs are used directly and are required to be synchronous single-cycle pulses. A held-high trigger re-sets pending every cycle, so the sequence restarts at every tick.

Test Plan:
- Reset mid-FLASH (TICK_DIV=4, ch0 at T3): pull reset_n low between clock edges -> led, busy, done read 0 immediately (async). After release, the prescaler restarts from 0.
- Basic flash (TICK_DIV=4, FLASH_COUNT=6): trigger[0] pulse -> led[0] follows 1,0,1,0,1,0 on consecutive ticks. done[0] is a single 1-cycle pulse at the 7th tick. busy[0] is high throughout. Other channels stay 0.
- Retrigger: trigger[1] at T0, second trigger[1] between T2 and T3 -> at T3 led[1]=1 and cnt reloads to 6. Exactly one done pulse, 6 ticks after T3.
- Cancel priority: trigger[2] and cancel[2] in the same cycle -> channel stays IDLE, busy[2]=0. Cancel during FLASH with led=1 -> led=0 next cycle, no done.
- Tick coincidence: trigger[3] asserted in the same cycle tick=1 -> ARMED, and FLASH starts at the next tick (TICK_DIV cycles later), not the current one.
- Multi-channel (FLASH_COUNT=1): trigger all 4 channels in the same cycle -> all led=1 for one tick, then 4 simultaneous done pulses. With FLASH_TRIG_SYNC_EN, a 10-cycle-high trigger produces one sequence.

Source files
------------

// File: rtl/flash_light_bank.sv
// Multi-channel LED flasher: one shared tick prescaler and CHANNELS independent IDLE/ARMED/FLASH engines.
// Define FLASH_TRIG_SYNC_EN to synchronise and edge-detect asynchronous trigger/cancel levels.
module flash_light_bank #(
    parameter int CHANNELS    = 4,
    parameter int TICK_DIV    = 20000000,
    parameter int FLASH_COUNT = 6,
    parameter int CNT_W       = 4
) (
    input  logic                clk_40MHz,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] trigger,
    input  logic [CHANNELS-1:0] cancel,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done,
    output logic                tick
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLASH_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FLASH = 2'd2
    } state_t;

    logic [PRE_W-1:0]    prescaler;
    logic [CHANNELS-1:0] trig_evt;
    logic [CHANNELS-1:0] canc_evt;

    // Free-running prescaler; triggers never restart it so all channels share one tick phase.
    always_ff @(posedge clk_40MHz or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= (prescaler == PRE_MAX);
            if (prescaler == PRE_MAX)
                prescaler <= '0;
            else
                prescaler <= prescaler + 1'b1;
        end
    end

`ifdef FLASH_TRIG_SYNC_EN
    logic [CHANNELS-1:0] trig_s1, trig_s2, trig_s3;
    logic [CHANNELS-1:0] canc_s1, canc_s2, canc_s3;

    // Two-flop synchroniser, then a registered rising-edge detector so a held level is one event.
    always_ff @(posedge clk_40MHz or negedge reset_n) begin
        if (!reset_n) begin
            trig_s1  <= '0;
            trig_s2  <= '0;
            trig_s3  <= '0;
            trig_evt <= '0;
            canc_s1  <= '0;
            canc_s2  <= '0;
            canc_s3  <= '0;
            canc_evt <= '0;
        end else begin
            trig_s1  <= trigger;
            trig_s2  <= trig_s1;
            trig_s3  <= trig_s2;
            trig_evt <= trig_s2 & ~trig_s3;
            canc_s1  <= cancel;
            canc_s2  <= canc_s1;
            canc_s3  <= canc_s2;
            canc_evt <= canc_s2 & ~canc_s3;
        end
    end
`else
    assign trig_evt = trigger;
    assign canc_evt = cancel;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             pending;
        logic             led_q;
        logic             busy_q;
        logic             done_q;

        // A trigger always lands in pending, even on the tick that consumes the previous one,
        // so a trigger coincident with tick is served on the following tick.
        always_ff @(posedge clk_40MHz or negedge reset_n) begin
            if (!reset_n) begin
                state   <= IDLE;
                cnt     <= '0;
                pending <= 1'b0;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (canc_evt[i]) begin
                state   <= IDLE;
                cnt     <= '0;
                pending <= 1'b0;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                done_q  <= 1'b0;
                pending <= trig_evt[i] | (pending & ~(tick & (state != IDLE)));
                case (state)
                    IDLE: begin
                        if (pending) begin
                            state  <= ARMED;
                            busy_q <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (tick) begin
                            state <= FLASH;
                            cnt   <= CNT_LOAD;
                            led_q <= 1'b1;
                        end
                    end
                    FLASH: begin
                        if (tick) begin
                            if (pending) begin
                                cnt   <= CNT_LOAD;
                                led_q <= 1'b1;
                            end else if (cnt > CNT_ONE) begin
                                cnt   <= cnt - 1'b1;
                                led_q <= ~led_q;
                            end else begin
                                cnt    <= '0;
                                led_q  <= 1'b0;
                                state  <= IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        led_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign led[i]  = led_q;
        assign busy[i] = busy_q;
        assign done[i] = done_q;
    end

endmodule

// File: tb/tb_flash_light_bank.sv
// Scoreboard bench for flash_light_bank: two instances (FLASH_COUNT 6 and 1) checked every cycle
// against a tick-level reference model of the flash rules.
module tb_flash_light_bank;

    localparam int CH = 4;
    localparam int TD = 4;
    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_FLASH = 2;

    typedef struct packed {
        logic [1:0][CH-1:0] led;
        logic [1:0][CH-1:0] busy;
        logic [1:0][CH-1:0] done;
        logic               tick;
    } exp_t;

    logic          clk_40MHz;
    logic          reset_n;
    logic [CH-1:0] trigger;
    logic [CH-1:0] cancel;
    logic [CH-1:0] led_a, busy_a, done_a;
    logic [CH-1:0] led_b, busy_b, done_b;
    logic          tick_a, tick_b;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    int m_st[2][CH];
    int m_rem[2][CH];
    bit m_pend[2][CH];
    int edge_cnt;
`ifdef FLASH_TRIG_SYNC_EN
    logic [CH-1:0] t_hist[4];
    logic [CH-1:0] c_hist[4];
`endif

    flash_light_bank #(.CHANNELS(CH), .TICK_DIV(TD), .FLASH_COUNT(6), .CNT_W(4)) u_dut_a (
        .clk_40MHz(clk_40MHz), .reset_n(reset_n), .trigger(trigger), .cancel(cancel),
        .led(led_a), .busy(busy_a), .done(done_a), .tick(tick_a)
    );

    flash_light_bank #(.CHANNELS(CH), .TICK_DIV(TD), .FLASH_COUNT(1), .CNT_W(4)) u_dut_b (
        .clk_40MHz(clk_40MHz), .reset_n(reset_n), .trigger(trigger), .cancel(cancel),
        .led(led_b), .busy(busy_b), .done(done_b), .tick(tick_b)
    );

    initial begin
        clk_40MHz = 1'b0;
        forever #5 clk_40MHz = ~clk_40MHz;
    end

    function automatic int flash_count(input int d);
        return (d == 0) ? 6 : 1;
    endfunction

    task automatic check_output(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        edge_cnt = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < CH; i++) begin
                m_st[d][i]   = S_IDLE;
                m_rem[d][i]  = 0;
                m_pend[d][i] = 1'b0;
            end
`ifdef FLASH_TRIG_SYNC_EN
        for (int j = 0; j < 4; j++) begin
            t_hist[j] = '0;
            c_hist[j] = '0;
        end
`endif
    endtask

    // Advances the reference by one clock edge; tick timing comes from the edge count since reset.
    task automatic model_step(input logic [CH-1:0] trig, input logic [CH-1:0] canc, output exp_t e);
        logic [CH-1:0] et, ec;
        bit tick_in;
        bit np;
        int fc;
        edge_cnt++;
        tick_in = (edge_cnt > 1) && ((edge_cnt - 1) % TD == 0);
`ifdef FLASH_TRIG_SYNC_EN
        et = t_hist[2] & ~t_hist[3];
        ec = c_hist[2] & ~c_hist[3];
        for (int j = 3; j > 0; j--) begin
            t_hist[j] = t_hist[j-1];
            c_hist[j] = c_hist[j-1];
        end
        t_hist[0] = trig;
        c_hist[0] = canc;
`else
        et = trig;
        ec = canc;
`endif
        e = '0;
        e.tick = (edge_cnt % TD == 0);
        for (int d = 0; d < 2; d++) begin
            fc = flash_count(d);
            for (int i = 0; i < CH; i++) begin
                if (ec[i]) begin
                    m_st[d][i]   = S_IDLE;
                    m_rem[d][i]  = 0;
                    m_pend[d][i] = 1'b0;
                end else begin
                    np = m_pend[d][i];
                    if (m_st[d][i] == S_IDLE) begin
                        if (m_pend[d][i]) m_st[d][i] = S_ARMED;
                    end else if (tick_in) begin
                        np = 1'b0;
                        if (m_st[d][i] == S_ARMED || m_pend[d][i]) begin
                            m_st[d][i]  = S_FLASH;
                            m_rem[d][i] = fc;
                        end else if (m_rem[d][i] > 1) begin
                            m_rem[d][i]--;
                        end else begin
                            m_rem[d][i] = 0;
                            m_st[d][i]  = S_IDLE;
                            e.done[d][i] = 1'b1;
                        end
                    end
                    if (et[i]) np = 1'b1;
                    m_pend[d][i] = np;
                end
                e.busy[d][i] = (m_st[d][i] != S_IDLE);
                e.led[d][i]  = (m_st[d][i] == S_FLASH) && (((fc - m_rem[d][i]) % 2) == 0);
            end
        end
    endtask

    task automatic apply_stimulus(input logic [CH-1:0] trig, input logic [CH-1:0] canc);
        exp_t e;
        trigger = trig;
        cancel  = canc;
        model_step(trig, canc, e);
        exp_q.push_back(e);
        @(negedge clk_40MHz);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) apply_stimulus('0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_led_a"}, led_a, '0);
        check_output({tag, "_busy_a"}, busy_a, '0);
        check_output({tag, "_done_a"}, done_a, '0);
        check_output({tag, "_tick_a"}, {3'b000, tick_a}, '0);
        check_output({tag, "_led_b"}, led_b, '0);
    endtask

    task automatic bound_check(input string name, input bit ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s actual=timeout required=condition_reached", name);
        end
    endtask

    // Monitor: every cycle the DUTs present outputs, pop the oldest expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_40MHz);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("led_fc6", led_a, e.led[0]);
                check_output("busy_fc6", busy_a, e.busy[0]);
                check_output("done_fc6", done_a, e.done[0]);
                check_output("tick_fc6", {3'b000, tick_a}, {3'b000, e.tick});
                check_output("led_fc1", led_b, e.led[1]);
                check_output("busy_fc1", busy_b, e.busy[1]);
                check_output("done_fc1", done_b, e.done[1]);
                check_output("tick_fc1", {3'b000, tick_b}, {3'b000, e.tick});
            end
        end
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        trigger  = '0;
        cancel   = '0;
        model_reset();
        repeat (3) @(posedge clk_40MHz);
        #1;
        check_reset_outputs("power_on_reset");
        @(negedge clk_40MHz);
        reset_n = 1'b1;

        // Basic single-channel flash
        apply_stimulus(4'b0001, '0);
        idle_cycles(8 * TD);

        // Retrigger mid-sequence on channel 1
        apply_stimulus(4'b0010, '0);
        idle_cycles(2 * TD + 2);
        apply_stimulus(4'b0010, '0);
        idle_cycles(9 * TD);

        // Trigger and cancel together, then cancel while the LED is lit
        apply_stimulus(4'b0100, 4'b0100);
        idle_cycles(2 * TD);
        apply_stimulus(4'b0100, '0);
        for (n = 0; n < 20 * TD && !(m_st[0][2] == S_FLASH && m_rem[0][2] == 6); n++)
            apply_stimulus('0, '0);
        bound_check("wait_flash_ch2", m_st[0][2] == S_FLASH);
        apply_stimulus('0, 4'b0100);
        idle_cycles(8 * TD);

        // Trigger coincident with tick
        for (n = 0; n < 2 * TD && (edge_cnt % TD != 0); n++) apply_stimulus('0, '0);
        bound_check("wait_tick_align", edge_cnt % TD == 0);
        apply_stimulus(4'b1000, '0);
        idle_cycles(9 * TD);

        // All channels together
        apply_stimulus(4'b1111, '0);
        idle_cycles(9 * TD);

        // Trigger held high for ten cycles
        for (int k = 0; k < 10; k++) apply_stimulus(4'b0001, '0);
        idle_cycles(10 * TD);

        // Randomised triggers and cancels
        for (int k = 0; k < 400; k++) begin
            logic [CH-1:0] t, c;
            for (int i = 0; i < CH; i++) begin
                t[i] = ($urandom_range(15) == 0);
                c[i] = ($urandom_range(31) == 0);
            end
            apply_stimulus(t, c);
        end
        idle_cycles(10 * TD);

        // Asynchronous reset in the middle of a flash sequence
        apply_stimulus(4'b0001, '0);
        for (n = 0; n < 20 * TD && !(m_st[0][0] == S_FLASH && m_rem[0][0] == 3); n++)
            apply_stimulus('0, '0);
        bound_check("wait_t3_ch0", m_st[0][0] == S_FLASH && m_rem[0][0] == 3);
        @(posedge clk_40MHz);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk_40MHz);
        model_reset();
        reset_n = 1'b1;
        idle_cycles(3 * TD);
        apply_stimulus(4'b0001, '0);
        idle_cycles(8 * TD);

        for (n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk_40MHz);
        #2;
        bound_check("scoreboard_drain", exp_q.size() == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
